// File: rtl/tv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tv_pkg
// Description : Shared encodings for the test-vector checker: reference gate
//               selection, FSM states, counter widths and pipeline depth limit.
// Revision    : 1.0 - initial release
// ============================================================================
package tv_pkg;

  // Result counter width and the extended width used for terminal detection
  localparam int CNT_W       = 8;
  localparam int CNT_EXT_W   = CNT_W + 1;

  // Deepest expected-value pipeline supported
  localparam int MAX_LATENCY = 8;

  // Reference function selection
  localparam logic [1:0] GATE_AND  = 2'd0;
  localparam logic [1:0] GATE_OR   = 2'd1;
  localparam logic [1:0] GATE_XOR  = 2'd2;
  localparam logic [1:0] GATE_NAND = 2'd3;

  // Checker sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Golden two-input gate used to build the expected response
  function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
    case (op)
      GATE_AND: gate_eval = a & b;
      GATE_OR:  gate_eval = a | b;
      GATE_XOR: gate_eval = a ^ b;
      default:  gate_eval = ~(a & b);
    endcase
  endfunction

endpackage : tv_pkg
`default_nettype wire

// File: rtl/exp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : exp_pipe
// Description : Enabled shift register carrying expected bits so that each one
//               emerges at the tail exactly DEPTH enabled cycles after entry.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // A single-stage pipe has no lower bits to shift, so it is built separately
  generate
    if (DEPTH == 1) begin : g_single
      always_comb sr_d = d;
    end else begin : g_multi
      always_comb sr_d = {sr_q[DEPTH-2:0], d};
    end
  endgenerate

  // Shift only on enabled cycles; clear asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (en) begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule : exp_pipe
`default_nettype wire

// File: rtl/tv_checker.sv
`default_nettype none
// ============================================================================
// Module      : tv_checker
// Description : Compares a DUT response against a reference gate delayed by
//               the DUT latency; counts vectors and mismatches and flags
//               pass/fail after NUM_VECTORS compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tv_checker
  import tv_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 4,
  parameter int GATE_OP     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in1,
  input  logic             in0,
  input  logic             out,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam int                   FILL_W    = $clog2(MAX_LATENCY + 1);
  localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(LATENCY - 1);
  localparam logic [CNT_EXT_W-1:0] NV_LAST   = CNT_EXT_W'(NUM_VECTORS);
  localparam logic [1:0]           GATE_SEL  = 2'(GATE_OP);
  localparam logic [CNT_W-1:0]     ERR_MAX   = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [CNT_EXT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     first_q, first_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;

  logic exp_bit;
  logic push;
  logic tail;

  assign exp_bit = gate_eval(GATE_SEL, in1, in0);

  exp_pipe #(
    .DEPTH (LATENCY)
  ) u_exp_pipe (
    .clk   (clk),
    .rst_n (rst),
    .en    (push),
    .d     (exp_bit),
    .q     (tail)
  );

  // Next-state, pipeline push and result-counter update
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (en) begin
          push = 1'b1;
          if (fill_q == FILL_LAST) state_d = ST_CHECK;
          else                     fill_d  = fill_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (en) begin
          push  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          // Case inequality so an X/Z response is never taken as a match
          if (out !== tail) begin
            if (err_q == '0)     first_d = cnt_q[CNT_W-1:0];
            if (err_q != ERR_MAX) err_d  = err_q + 1'b1;
          end
          // Terminal count uses the wide counter so 256 vectors end at wrap
          if (cnt_d == NV_LAST) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
    fail_d = done_d && (err_d != '0);
  end

  // Single state register for FSM, counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign vec_cnt   = cnt_q[CNT_W-1:0];
  assign err_cnt   = err_q;
  assign first_err = first_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule : tv_checker
`default_nettype wire

// File: tb/tb_tv_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tv_checker
// Description : Four checker configurations driven by shared stimulus; each
//               has an emulated DUT response and a scoreboard reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tv_checker;

  localparam int NI = 4;
  localparam int LAT [NI] = '{1, 3, 1, 8};
  localparam int NVS [NI] = '{4, 8, 256, 6};
  localparam int OPS [NI] = '{0, 2, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic in1 = 1'b0;
  logic in0 = 1'b0;
  logic outs [NI];

  logic [7:0] vc [NI];
  logic [7:0] ec [NI];
  logic [7:0] fe [NI];
  logic       dn [NI];
  logic       ps [NI];
  logic       fl [NI];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state per instance (0 idle, 1 fill, 2 check, 3 done)
  int m_state [NI];
  int m_fill  [NI];
  int m_cnt   [NI];
  int m_err   [NI];
  int m_first [NI];
  bit sb_q    [NI][$];

  // Emulated DUT controls
  bit [1:0] hist [$];
  int dly    [NI];
  bit stuck0 [NI];
  bit hit01  [NI];

  always #5 clk = ~clk;

  tv_checker #(.LATENCY(LAT[0]), .NUM_VECTORS(NVS[0]), .GATE_OP(OPS[0])) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in0(in0), .out(outs[0]),
    .vec_cnt(vc[0]), .err_cnt(ec[0]), .first_err(fe[0]), .done(dn[0]), .pass(ps[0]), .fail(fl[0]));
  tv_checker #(.LATENCY(LAT[1]), .NUM_VECTORS(NVS[1]), .GATE_OP(OPS[1])) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in0(in0), .out(outs[1]),
    .vec_cnt(vc[1]), .err_cnt(ec[1]), .first_err(fe[1]), .done(dn[1]), .pass(ps[1]), .fail(fl[1]));
  tv_checker #(.LATENCY(LAT[2]), .NUM_VECTORS(NVS[2]), .GATE_OP(OPS[2])) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in0(in0), .out(outs[2]),
    .vec_cnt(vc[2]), .err_cnt(ec[2]), .first_err(fe[2]), .done(dn[2]), .pass(ps[2]), .fail(fl[2]));
  tv_checker #(.LATENCY(LAT[3]), .NUM_VECTORS(NVS[3]), .GATE_OP(OPS[3])) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in0(in0), .out(outs[3]),
    .vec_cnt(vc[3]), .err_cnt(ec[3]), .first_err(fe[3]), .done(dn[3]), .pass(ps[3]), .fail(fl[3]));

  task automatic chk(input string tag, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit ref_gate(input int op, input bit a, input bit b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Response of a DUT whose output trails its inputs by dly enabled cycles
  function automatic bit emu_out(input int i);
    bit [1:0] v;
    if (stuck0[i]) return 1'b0;
    if (hist.size() < dly[i]) return 1'b0;
    v = hist[hist.size() - dly[i]];
    if (hit01[i] && v == 2'b01) return 1'b1;
    return ref_gate(OPS[i], v[1], v[0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_state[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_first[i] = 0;
      sb_q[i].delete();
    end
    hist.delete();
  endtask

  task automatic model_edge(input int i, input bit e, input bit [1:0] v, input bit o);
    bit exp_b;
    case (m_state[i])
      0: if (e) begin m_state[i] = 1; m_fill[i] = 0; end
      1: if (e) begin
           sb_q[i].push_back(ref_gate(OPS[i], v[1], v[0]));
           m_fill[i]++;
           if (m_fill[i] == LAT[i]) m_state[i] = 2;
         end
      2: if (e) begin
           exp_b = sb_q[i].pop_front();
           sb_q[i].push_back(ref_gate(OPS[i], v[1], v[0]));
           if (o != exp_b) begin
             if (m_err[i] == 0) m_first[i] = m_cnt[i] % 256;
             if (m_err[i] < 255) m_err[i]++;
           end
           m_cnt[i]++;
           if (m_cnt[i] == NVS[i]) m_state[i] = 3;
         end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input int i);
    bit md;
    md = (m_state[i] == 3);
    chk($sformatf("vec_cnt[%0d]", i),   {1'b0, vc[i]}, 9'(m_cnt[i] % 256));
    chk($sformatf("err_cnt[%0d]", i),   {1'b0, ec[i]}, 9'(m_err[i]));
    chk($sformatf("first_err[%0d]", i), {1'b0, fe[i]}, 9'(m_first[i]));
    chk($sformatf("done[%0d]", i),      {8'd0, dn[i]}, {8'd0, md});
    chk($sformatf("pass[%0d]", i),      {8'd0, ps[i]}, {8'd0, md && m_err[i] == 0});
    chk($sformatf("fail[%0d]", i),      {8'd0, fl[i]}, {8'd0, md && m_err[i] != 0});
  endtask

  task automatic step(input bit e, input bit [1:0] v);
    en = e;
    {in1, in0} = v;
    for (int i = 0; i < NI; i++) outs[i] = emu_out(i);
    @(posedge clk);
    if (e) hist.push_back(v);
    for (int i = 0; i < NI; i++) model_edge(i, e, v, outs[i]);
    #1;
    for (int i = 0; i < NI; i++) check_outputs(i);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_outputs(i);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Idle edge, then vectors 00,01,10,11 repeating; optional 5-cycle en gap
  task automatic run_main(input bit with_gap);
    for (int i = 0; i < NI; i++) begin dly[i] = LAT[i]; hit01[i] = 1'b0; end
    stuck0[2] = 1'b1;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    step(1'b1, 2'b11);
    for (int k = 0; k < 260; k++) begin
      step(1'b1, 2'(k % 4));
      if (with_gap && k == 5) begin
        for (int g = 0; g < 5; g++) begin
          step(1'b0, 2'(g));
          chk("gap_vec1", {1'b0, vc[1]}, 9'd3);
          chk("gap_err1", {1'b0, ec[1]}, 9'd0);
        end
      end
    end
    chk("main_vec0",  {1'b0, vc[0]}, 9'd4);
    chk("main_err0",  {1'b0, ec[0]}, 9'd0);
    chk("main_pass0", {8'd0, ps[0]}, 9'd1);
    chk("main_vec1",  {1'b0, vc[1]}, 9'd8);
    chk("main_pass1", {8'd0, ps[1]}, 9'd1);
    chk("main_err2",  {1'b0, ec[2]}, 9'd192);
    chk("main_done2", {8'd0, dn[2]}, 9'd1);
    chk("main_vec2",  {1'b0, vc[2]}, 9'd0);
    chk("main_vec3",  {1'b0, vc[3]}, 9'd6);
    chk("main_pass3", {8'd0, ps[3]}, 9'd1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      outs[i] = 1'b0; dly[i] = LAT[i]; stuck0[i] = 1'b0; hit01[i] = 1'b0;
    end

    // Power-up reset and a full run including an enable gap
    do_reset();
    run_main(1'b1);

    // Injected faults: forced 1 on vector 01, and a 2-cycle DUT on a 3-deep checker
    do_reset();
    hit01[0] = 1'b1;
    dly[1]   = 2;
    step(1'b1, 2'b11);
    for (int k = 0; k < 20; k++) step(1'b1, 2'(k % 4));
    chk("flt_err0",   {1'b0, ec[0]}, 9'd1);
    chk("flt_first0", {1'b0, fe[0]}, 9'd1);
    chk("flt_fail0",  {8'd0, fl[0]}, 9'd1);
    chk("flt_pass0",  {8'd0, ps[0]}, 9'd0);
    chk("flt_fail1",  {8'd0, fl[1]}, 9'd1);

    // Asynchronous reset mid-check once instance 2 has two mismatches
    do_reset();
    hit01[0] = 1'b0;
    dly[1]   = 3;
    step(1'b1, 2'b11);
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k % 4));
    chk("pre_rst_err2", {1'b0, ec[2]}, 9'd2);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("arst_vec[%0d]", i),   {1'b0, vc[i]}, 9'd0);
      chk($sformatf("arst_err[%0d]", i),   {1'b0, ec[i]}, 9'd0);
      chk($sformatf("arst_first[%0d]", i), {1'b0, fe[i]}, 9'd0);
      chk($sformatf("arst_flags[%0d]", i), {6'd0, dn[i], ps[i], fl[i]}, 9'd0);
    end
    do_reset();
    run_main(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_tv_checker
`default_nettype wire
